// File: rtl/apb4_mem_slave_if.sv
// rtl/apb4_mem_slave_if.sv - APB4 bus bundle between the bridge fan-out and the memory slave
interface apb4_mem_slave_if #(
  parameter int pdataWidth = 32
);
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [31:0]               PADDR;
  logic [pdataWidth-1:0]     PWDATA;
  logic [pdataWidth/8-1:0]   PSTRB;
  logic [pdataWidth-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_mem_slave.sv
// rtl/apb4_mem_slave.sv - APB4 memory slave with byte strobes, error response and wait states
module apb4_mem_slave #(
  parameter int pdataWidth = 32,
  parameter int memWords   = 256,
  parameter int rdWait     = 1,
  parameter int wrWait     = 0
) (
  input logic             PCLK,
  input logic             PRESET,
  apb4_mem_slave_if.slave bus
);

  localparam int BYTES = pdataWidth / 8;
  localparam int LSB   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IW    = $clog2(memWords);

  // SETUP is the bus setup phase. Coming from IDLE the setup phase is
  // recognised in the same cycle the request appears; the SETUP state is
  // only occupied when a transfer follows a completion with PSEL held high.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  state_t                next_state;
  logic [pdataWidth-1:0] mem [memWords];
  logic [3:0]            cnt;
  logic                  err_q;
  logic [IW-1:0]         idx_q;
  logic [pdataWidth-1:0] rdata_q;
  logic [31:0]           idx_full;
  logic                  addr_err;
  logic                  setup_go;
  logic                  ready;
  logic                  slverr;
  logic                  wr_commit;

  assign bus.PRDATA  = rdata_q;
  assign bus.PREADY  = ready;
  assign bus.PSLVERR = slverr;

  // Word index and illegal-address detection (misaligned or beyond the array)
  always_comb begin
    idx_full = bus.PADDR >> LSB;
    addr_err = (|(bus.PADDR & 32'(BYTES - 1))) || (idx_full >= 32'(memWords));
  end

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    setup_go   = 1'b0;
    ready      = 1'b0;
    slverr     = 1'b0;
    wr_commit  = 1'b0;
    case (state)
      IDLE, SETUP: begin
        if (bus.PSEL && !bus.PENABLE) begin
          setup_go   = 1'b1;
          next_state = ACCESS;
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        ready  = (cnt == 4'd0);
        slverr = ready && err_q;
        if (!bus.PSEL || !bus.PENABLE) begin
          next_state = IDLE;
        end else if (ready) begin
          wr_commit  = bus.PWRITE && !err_q;
          next_state = SETUP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Setup-phase capture: error flag, word index, wait count and read data
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt     <= 4'd0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else if (setup_go) begin
      err_q <= addr_err;
      idx_q <= idx_full[IW-1:0];
      if (addr_err)        cnt <= 4'd0;
      else if (bus.PWRITE) cnt <= 4'(wrWait);
      else                 cnt <= 4'(rdWait);
      if (!bus.PWRITE) begin
        rdata_q <= addr_err ? '0 : mem[idx_full[IW-1:0]];
      end
    end else if (state == ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Byte-lane write into the array; the array itself is never reset
  always_ff @(posedge PCLK) begin
    if (wr_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.PSTRB[b]) mem[idx_q][8*b +: 8] <= bus.PWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// tb/tb_apb4_mem_slave.sv - directed self-checking bench for apb4_mem_slave
module tb_apb4_mem_slave;

  logic PCLK;
  logic PRESET;
  int   n_checks;
  int   n_pass;
  logic ok;

  apb4_mem_slave_if #(.pdataWidth(32)) bus ();

  apb4_mem_slave #(
    .pdataWidth(32),
    .memWords  (200),
    .rdWait    (2),
    .wrWait    (1)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One complete transfer starting at posedge+1; returns at posedge+1 after completion
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input int exp_waits, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic hold);
    int w;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    bus.PSTRB   = strb;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    w = 0;
    @(negedge PCLK);
    while (!bus.PREADY && w < 20) begin
      w++;
      @(negedge PCLK);
    end
    check({tag, "_waits"}, 32'(w), 32'(exp_waits));
    check({tag, "_slverr"}, {31'd0, bus.PSLVERR}, {31'd0, exp_err});
    check({tag, "_prdata"}, bus.PRDATA, exp_rdata);
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b0;
    if (!hold) bus.PSEL = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    PRESET      = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 32'd0;
    bus.PWDATA  = 32'd0;
    bus.PSTRB   = 4'd0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready",  {31'd0, bus.PREADY},  32'd0);
    check("rst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
    check("rst_prdata",  bus.PRDATA,           32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Full-word write then read
    xfer("wr_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0,        1'b0, 1'b0);
    xfer("rd_full", 1'b0, 32'h10, 32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0);

    // Partial strobes: lanes 0 and 2
    xfer("wr_strb", 1'b1, 32'h10, 32'h11223344, 4'h5, 1, 32'hDEADBEEF, 1'b0, 1'b0);
    xfer("rd_strb", 1'b0, 32'h10, 32'h0,        4'h0, 2, 32'hDE22BE44, 1'b0, 1'b0);

    // Out-of-range read and misaligned write complete at once with error
    xfer("rd_oor",  1'b0, 32'h320, 32'h0,        4'h0, 0, 32'h0,        1'b1, 1'b0);
    xfer("wr_mis",  1'b1, 32'h12,  32'h99999999, 4'hF, 0, 32'h0,        1'b1, 1'b0);
    xfer("rd_keep", 1'b0, 32'h10,  32'h0,        4'h0, 2, 32'hDE22BE44, 1'b0, 1'b0);

    // Back-to-back write then read with PSEL held high
    xfer("wr_b2b", 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 1, 32'hDE22BE44, 1'b0, 1'b1);
    xfer("rd_b2b", 1'b0, 32'h0, 32'h0,        4'h0, 2, 32'hA5A5A5A5, 1'b0, 1'b0);

    // Zero-strobe write is a legal no-op
    xfer("wr_nostrb", 1'b1, 32'h0, 32'h12345678, 4'h0, 1, 32'hA5A5A5A5, 1'b0, 1'b0);
    xfer("rd_nostrb", 1'b0, 32'h0, 32'h0,        4'h0, 2, 32'hA5A5A5A5, 1'b0, 1'b0);

    // Reset during the first read wait cycle
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 32'h10;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #1 PRESET = 1'b1;
    #1;
    check("midrst_pready", {31'd0, bus.PREADY}, 32'd0);
    check("midrst_prdata", bus.PRDATA,          32'd0);
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      if (bus.PREADY) ok = 1'b0;
    end
    check("midrst_no_spurious", {31'd0, ok}, 32'd1);
    @(posedge PCLK); #1;
    xfer("rd_after_rst", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDE22BE44, 1'b0, 1'b0);

    // PENABLE dropped during a write wait cycle aborts the transfer
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 32'h10;
    bus.PWDATA  = 32'hFFFFFFFF;
    bus.PSTRB   = 4'hF;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #1;
    check("abort_wait_pready", {31'd0, bus.PREADY}, 32'd0);
    #1 bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0;
    check("abort_pready_1", {31'd0, bus.PREADY}, 32'd0);
    @(posedge PCLK); #1;
    check("abort_pready_2", {31'd0, bus.PREADY}, 32'd0);
    xfer("rd_after_abort", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDE22BE44, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
